// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector with runtime overlap mode,
// an input-valid qualifier, a saturating match counter and a synchronous clear.
module moore_seq_detector_param #(
  parameter int unsigned     N       = 5,
  parameter logic [N-1:0]    PATTERN = N'(5'b11011),
  parameter int unsigned     CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap_en,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned SW = $clog2(N + 1);

  localparam logic [SW-1:0]    ST_IDLE  = '0;
  localparam logic [SW-1:0]    ST_MATCH = SW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("moore_seq_detector_param: N must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("moore_seq_detector_param: CNT_W must be in 1..32");
  end

  // Pattern bit in arrival order: index 0 is the first bit received.
  function automatic logic pat_bit(input int unsigned idx);
    logic [N-1:0] sh;
    sh = PATTERN >> (N - 1 - idx);
    return sh[0];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned delta_f(input int unsigned k, input logic b);
    int unsigned best;
    best = 0;
    for (int unsigned len = 1; len <= k + 1; len++) begin
      logic ok;
      ok = (pat_bit(len - 1) == b);
      for (int unsigned j = 0; j + 1 < len; j++) begin
        if (pat_bit(k + 1 - len + j) != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int unsigned fail_f();
    int unsigned best;
    best = 0;
    for (int unsigned len = 1; len < N; len++) begin
      logic ok;
      ok = 1'b1;
      for (int unsigned j = 0; j < len; j++) begin
        if (pat_bit(N - len + j) != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = len;
    end
    return best;
  endfunction

  localparam int unsigned FAIL_LEN = fail_f();

  // Elaboration-time transition table; row N holds the overlapping exit from match.
  logic [SW-1:0] nxt_tbl [N+1][2];

  for (genvar k = 0; k <= N; k++) begin : g_row
    localparam int unsigned SRC = (32'(k) == N) ? FAIL_LEN : 32'(k);
    assign nxt_tbl[k][0] = SW'(delta_f(SRC, 1'b0));
    assign nxt_tbl[k][1] = SW'(delta_f(SRC, 1'b1));
  end

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             sat_q, sat_d;

  // Next state and counter; clear wins over a valid bit on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q > ST_MATCH) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      if (state_q == ST_MATCH && !overlap_en) begin
        state_d = nxt_tbl[0][in];
      end else begin
        state_d = nxt_tbl[state_q][in];
      end
      if (state_d == ST_MATCH && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    out_d = (state_d == ST_MATCH);
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Scoreboard bench for moore_seq_detector_param: default 11011 instance and a
// 1010 / CNT_W=2 instance share one stimulus stream against a history-window model.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, in_bit, in_valid, overlap_en, clear;
  logic       out_a, sat_a, out_b, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  moore_seq_detector_param dut_a (
    .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
    .overlap_en(overlap_en), .clear(clear),
    .out(out_a), .match_count(cnt_a), .count_sat(sat_a)
  );

  moore_seq_detector_param #(.N(4), .PATTERN(4'b1010), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_bit), .in_valid(in_valid),
    .overlap_en(overlap_en), .clear(clear),
    .out(out_b), .match_count(cnt_b), .count_sat(sat_b)
  );

  typedef struct {
    bit out;
    int cnt;
    bit sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: last-N-bits window since reset/clear, restarted on a non-overlapping exit.
  int m_n   [2] = '{5, 4};
  int m_pat [2] = '{27, 10};
  int m_max [2] = '{255, 3};
  int m_bits[2] = '{0, 0};
  int m_len [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  bit m_inm [2] = '{0, 0};

  function automatic exp_t model_step(input int i, input bit r, input bit c,
                                      input bit v, input bit b, input bit ov);
    exp_t e;
    if (!r || c) begin
      m_bits[i] = 0;
      m_len[i]  = 0;
      m_inm[i]  = 0;
      m_cnt[i]  = 0;
    end else if (v) begin
      if (m_inm[i] && !ov) begin
        m_bits[i] = 0;
        m_len[i]  = 0;
      end
      m_bits[i] = ((m_bits[i] << 1) | int'(b)) & ((1 << m_n[i]) - 1);
      if (m_len[i] < m_n[i]) m_len[i]++;
      m_inm[i] = (m_len[i] == m_n[i]) && (m_bits[i] == m_pat[i]);
      if (m_inm[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
    end
    e.out = m_inm[i];
    e.cnt = m_cnt[i];
    e.sat = (m_cnt[i] == m_max[i]);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_out", 32'(out_a), 32'(e.out));
        check("a_count", 32'(cnt_a), 32'(e.cnt));
        check("a_sat", 32'(sat_a), 32'(e.sat));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_out", 32'(out_b), 32'(e.out));
        check("b_count", 32'(cnt_b), 32'(e.cnt));
        check("b_sat", 32'(sat_b), 32'(e.sat));
      end
    end
  end

  task automatic drive(input bit r, input bit c, input bit v, input bit b, input bit ov);
    @(negedge clk);
    rst        = r;
    clear      = c;
    in_valid   = v;
    in_bit     = b;
    overlap_en = ov;
    q_a.push_back(model_step(0, r, c, v, b, ov));
    q_b.push_back(model_step(1, r, c, v, b, ov));
  endtask

  task automatic send_bits(input logic [15:0] bits, input int len, input bit ov);
    logic [15:0] t;
    for (int i = len - 1; i >= 0; i--) begin
      t = bits >> i;
      drive(1'b1, 1'b0, 1'b1, t[0], ov);
    end
  endtask

  task automatic do_clear();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  initial begin
    bit ov;
    rst        = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    overlap_en = 1'b1;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    check("reset_out", 32'(out_a), 32'd0);
    check("reset_count", 32'(cnt_a), 32'd0);

    send_bits(16'b11011011, 8, 1'b1);
    drain();
    check("overlap_count", 32'(cnt_a), 32'd2);
    check("overlap_out", 32'(out_a), 32'd1);
    do_clear();

    send_bits(16'b11011011, 8, 1'b0);
    drain();
    check("nonoverlap_count", 32'(cnt_a), 32'd1);
    check("nonoverlap_out", 32'(out_a), 32'd0);
    do_clear();

    send_bits(16'b11, 2, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(16'b011, 3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'(i), 1'(i));
    drain();
    check("gap_out_held", 32'(out_a), 32'd1);
    check("gap_count", 32'(cnt_a), 32'd1);
    do_clear();

    send_bits(16'b1111011, 7, 1'b1);
    drain();
    check("extra_ones_count", 32'(cnt_a), 32'd1);
    check("extra_ones_out", 32'(out_a), 32'd1);
    do_clear();

    send_bits(16'b1101, 4, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_bits(16'b1, 1, 1'b1);
    drain();
    check("rst_recover_out", 32'(out_a), 32'd0);
    check("rst_recover_count", 32'(cnt_a), 32'd0);

    send_bits(16'b1101, 4, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    send_bits(16'b1, 1, 1'b1);
    drain();
    check("clr_recover_out", 32'(out_a), 32'd0);
    check("clr_recover_count", 32'(cnt_a), 32'd0);
    do_clear();

    send_bits(16'b1010101010, 10, 1'b1);
    drain();
    check("sat_count", 32'(cnt_b), 32'd3);
    check("sat_flag", 32'(sat_b), 32'd1);
    check("sat_out", 32'(out_b), 32'd1);

    ov = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 30) == 0) ov = ~ov;
      drive(1'($urandom_range(0, 299) != 0),
            1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0),
            ov);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
